// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised serial pattern detector.
// Builds the KMP prefix-automaton transition table from the pattern.
package seq_det_pkg;

  localparam int MAX_W   = 16;
  localparam int ST_BITS = 5;

  // tab[state][x] -> next state; row MAX_W is only meaningful up to the pattern length
  typedef logic [MAX_W:0][1:0][ST_BITS-1:0] nxt_tab_t;

  function automatic int calc_sw(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic pat_bit(input logic [MAX_W-1:0] pat, input int w, input int i);
    return pat[w-1-i];
  endfunction

  // Row w (accept state) holds the overlapping exit; the non-overlapping exit reuses row 0.
  function automatic nxt_tab_t build_tab(input int w, input logic [MAX_W-1:0] pat);
    nxt_tab_t tab;
    int       pi_arr [0:MAX_W];
    int       k;
    tab = '0;
    for (int i = 0; i <= MAX_W; i++) pi_arr[i] = 0;
    k = 0;
    for (int i = 1; i < w; i++) begin
      while (k > 0 && pat_bit(pat, w, i) != pat_bit(pat, w, k)) k = pi_arr[k];
      if (pat_bit(pat, w, i) == pat_bit(pat, w, k)) k++;
      pi_arr[i+1] = k;
    end
    for (int s = 0; s <= w; s++) begin
      for (int b = 0; b < 2; b++) begin
        if (s < w && 1'(b) == pat_bit(pat, w, s)) tab[s][b] = ST_BITS'(s + 1);
        else if (s == 0) tab[s][b] = '0;
        else tab[s][b] = tab[pi_arr[s]][b];
      end
    end
    return tab;
  endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state lookup for the pattern detector; the table is a constant
// built at elaboration, so this reduces to a small ROM-like decode on (state, x, overlap).
module seq_det_next
  import seq_det_pkg::*;
#(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
  parameter int                SW      = 3
) (
  input  logic [SW-1:0] state_i,
  input  logic          x_i,
  input  logic          overlap_i,
  output logic [SW-1:0] state_o
);

  localparam nxt_tab_t TAB = build_tab(PAT_W, 16'(PATTERN));

  logic [ST_BITS-1:0] idx;

  always_comb begin
    idx = ST_BITS'(state_i);
    if (state_i == SW'(PAT_W) && !overlap_i) idx = '0;
    state_o = SW'(TAB[idx][x_i]);
  end

endmodule

// File: rtl/seq_detect_machine.sv
// Serial pattern detector with Moore match flag and saturating match counter.
// Optional macro SEQ_DET_HIST_EN adds HIST, the last PAT_W sampled bits (newest in bit 0).
module seq_detect_machine
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8,
  localparam int              SW      = calc_sw(PAT_W)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  output logic             F,
  output logic [SW-1:0]    S,
  output logic [CNT_W-1:0] MATCH_CNT
`ifdef SEQ_DET_HIST_EN
  ,
  output logic [PAT_W-1:0] HIST
`endif
);

  logic [SW-1:0]    s_q, s_d;
  logic             f_q;
  logic [CNT_W-1:0] cnt_q;

  seq_det_next #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .SW     (SW)
  ) u_next (
    .state_i  (s_q),
    .x_i      (x),
    .overlap_i(overlap),
    .state_o  (s_d)
  );

  // F is registered from the next state so it always equals (S == PAT_W)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s_q   <= '0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else if (en) begin
      s_q <= s_d;
      f_q <= (s_d == SW'(PAT_W));
      if (s_d == SW'(PAT_W) && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SEQ_DET_HIST_EN
  logic [PAT_W-1:0] hist_q;

  always_ff @(posedge CLK) begin
    if (!RESET) hist_q <= '0;
    else if (en) hist_q <= {hist_q[PAT_W-2:0], x};
  end

  assign HIST = hist_q;
`endif

  assign S         = s_q;
  assign F         = f_q;
  assign MATCH_CNT = cnt_q;

endmodule

// File: tb/tb_seq_detect_machine.sv
// Bench for seq_detect_machine: two instances (1101/8-bit counter, 1111/2-bit counter)
// compared every cycle against a bit-history reference model, plus directed scenarios.
module tb_seq_detect_machine;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       x = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b0;
  logic       f_a, f_b;
  logic [2:0] s_a, s_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
`ifdef SEQ_DET_HIST_EN
  logic [3:0] hist_a, hist_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, index 0 = instance a, 1 = instance b
  logic [15:0] m_pat  [2];
  int          m_cmax [2];
  logic [15:0] m_buf  [2];
  int          m_n    [2];
  int          m_st   [2];
  int          m_cnt  [2];
  logic [15:0] m_hist [2];

  localparam int W = 4;

  always #5 CLK = ~CLK;

  seq_detect_machine #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) u_a (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .overlap(overlap),
    .F(f_a), .S(s_a), .MATCH_CNT(cnt_a)
`ifdef SEQ_DET_HIST_EN
    , .HIST(hist_a)
`endif
  );

  seq_detect_machine #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) u_b (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .overlap(overlap),
    .F(f_b), .S(s_b), .MATCH_CNT(cnt_b)
`ifdef SEQ_DET_HIST_EN
    , .HIST(hist_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp_v, $time);
  endtask

  // largest k such that the last k bits since the last restart equal the top k pattern bits
  function automatic int best_k(input logic [15:0] b, input int n, input logic [15:0] pat);
    bit ok;
    for (int k = n; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (b[k-1-j] != pat[W-1-j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic xv, input logic ev, input logic ov, input logic rv);
    for (int i = 0; i < 2; i++) begin
      if (!rv) begin
        m_buf[i] = '0; m_n[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_hist[i] = '0;
      end else if (ev) begin
        if (m_st[i] == W && !ov) m_n[i] = 0;
        m_buf[i]  = {m_buf[i][14:0], xv};
        m_n[i]    = (m_n[i] + 1 > W) ? W : m_n[i] + 1;
        m_st[i]   = best_k(m_buf[i], m_n[i], m_pat[i]);
        if (m_st[i] == W && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
        m_hist[i] = {m_hist[i][14:0], xv};
      end
    end
  endtask

  task automatic check_all();
    chk("a_S",   32'(s_a),   32'(m_st[0]));
    chk("a_F",   32'(f_a),   32'(m_st[0] == W));
    chk("a_CNT", 32'(cnt_a), 32'(m_cnt[0]));
    chk("b_S",   32'(s_b),   32'(m_st[1]));
    chk("b_F",   32'(f_b),   32'(m_st[1] == W));
    chk("b_CNT", 32'(cnt_b), 32'(m_cnt[1]));
`ifdef SEQ_DET_HIST_EN
    chk("a_HIST", 32'(hist_a), 32'(m_hist[0][3:0]));
    chk("b_HIST", 32'(hist_b), 32'(m_hist[1][3:0]));
`endif
  endtask

  task automatic step(input logic xv, input logic ev, input logic ov, input logic rv);
    @(negedge CLK);
    x = xv; en = ev; overlap = ov; RESET = rv;
    @(posedge CLK);
    model_edge(xv, ev, ov, rv);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send(input logic [15:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b1);
  endtask

  initial begin
    m_pat[0] = 16'b1101; m_cmax[0] = 255;
    m_pat[1] = 16'b1111; m_cmax[1] = 3;

    do_reset();
    chk("rst_S", 32'(s_a), 32'd0);
    chk("rst_F", 32'(f_a), 32'd0);
    chk("rst_CNT", 32'(cnt_a), 32'd0);

    send(16'b1101101, 7, 1'b1);
    chk("ovl_cnt", 32'(cnt_a), 32'd2);
    chk("ovl_F", 32'(f_a), 32'd1);

    do_reset();
    send(16'b1101101, 7, 1'b0);
    chk("novl_cnt", 32'(cnt_a), 32'd1);
    chk("novl_S", 32'(s_a), 32'd1);

    do_reset();
    send(16'b111111, 6, 1'b1);
    chk("ones_ovl_cnt", 32'(cnt_b), 32'd3);
    chk("ones_ovl_S", 32'(s_b), 32'd4);

    do_reset();
    send(16'b111111, 6, 1'b0);
    chk("ones_novl_cnt", 32'(cnt_b), 32'd1);

    do_reset();
    send(16'b1111111111, 10, 1'b1);
    chk("b_sat_cnt", 32'(cnt_b), 32'd3);
    chk("b_sat_F", 32'(f_b), 32'd1);

    do_reset();
    send(16'b110, 3, 1'b1);
    do_reset();
    chk("midrst_S", 32'(s_a), 32'd0);
    send(16'b1, 1, 1'b1);
    chk("midrst_S1", 32'(s_a), 32'd1);
    chk("midrst_F", 32'(f_a), 32'd0);
    chk("midrst_cnt", 32'(cnt_a), 32'd0);

    do_reset();
    send(16'b11, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'(i), 1'b0, 1'b1, 1'b1);
      chk("hold_S", 32'(s_a), 32'd2);
    end
    send(16'b01, 2, 1'b1);
    chk("en_F", 32'(f_a), 32'd1);
`ifdef SEQ_DET_HIST_EN
    chk("en_HIST", 32'(hist_a), 32'b1101);
`endif

    do_reset();
    for (int i = 0; i < 260; i++) send(16'b1101, 4, 1'b1);
    chk("a_sat_cnt", 32'(cnt_a), 32'd255);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 80) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(99) < 2) ? 1'b0 : 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
